// File: rtl/mips_pkg.sv
// Shared encodings for the EX stage: ALU operation codes, EX FSM states and
// the multiply/divide iteration bound. The DIV state is only present when
// the EX_DIV_EN macro is defined.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_AND   = 4'd0,
    ALU_OR    = 4'd1,
    ALU_ADD   = 4'd2,
    ALU_SUB   = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_MULTU = 4'd6,
    ALU_DIVU  = 4'd7,
    ALU_MFHI  = 4'd8,
    ALU_MFLO  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef EX_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_DONE = 2'd3
  } ex_state_e;

  // Iteration counter value on the 32nd (final) multiply/divide step.
  localparam logic [4:0] MD_LAST = 5'd31;

  // Branch target: PC+4 plus word-scaled immediate, wrapping modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [31:0] imm);
    return pc4 + {imm[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply / restoring divide datapath, one bit per step.
// acc holds {partial product, multiplier} for MULTU and {remainder,
// dividend/quotient} for DIVU. nxt_hi/nxt_lo expose the value acc takes after
// the current step so the controller can capture the result on the last step.
// Divider hardware is present only with EX_DIV_EN defined.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef EX_DIV_EN
  input  logic        mode_div,
`endif
  input  logic        step,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] nxt_hi,
  output logic [31:0] nxt_lo
);

  logic [63:0] acc;
  logic [63:0] acc_next;
  logic [31:0] d;
  logic [32:0] sum;
`ifdef EX_DIV_EN
  logic        is_div;
  logic [32:0] r_shift;
  logic [32:0] diff;
`endif

  // One shift-add (or shift-subtract) iteration.
  always_comb begin
    sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, d} : 33'd0);
    acc_next = {sum, acc[31:1]};
`ifdef EX_DIV_EN
    r_shift  = acc[63:31];
    diff     = r_shift - {1'b0, d};
    if (is_div) begin
      // A zero divisor never borrows, so quotient becomes all ones and the
      // remainder ends up equal to the dividend without special casing.
      if (!diff[32]) acc_next = {diff[31:0], acc[30:0], 1'b1};
      else           acc_next = {r_shift[31:0], acc[30:0], 1'b0};
    end
`endif
  end

  assign nxt_hi = acc_next[63:32];
  assign nxt_lo = acc_next[31:0];

  // Operand latch on start, one iteration per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      d   <= '0;
`ifdef EX_DIV_EN
      is_div <= 1'b0;
`endif
    end else if (start) begin
`ifdef EX_DIV_EN
      is_div <= mode_div;
      if (mode_div) begin
        d   <= op_b;
        acc <= {32'd0, op_a};
      end else begin
        d   <= op_a;
        acc <= {32'd0, op_b};
      end
`else
      d   <= op_a;
      acc <= {32'd0, op_b};
`endif
    end else if (step) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS-style EX stage: single-cycle ALU, branch target adder, HI/LO registers
// and an FSM sequencing the iterative MULTU/DIVU datapath (ex_muldiv).
// Optional: define EX_DIV_EN to include DIVU; otherwise op 7 is reserved.
module ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_add,
  input  logic [31:0] in_dato1,
  input  logic [31:0] in_dato2,
  input  logic [31:0] in_extend,
  input  logic [4:0]  in_b20_16,
  input  logic [4:0]  in_b15_11,
  input  logic [3:0]  in_alu_op,
  input  logic        in_alu_src,
  input  logic        in_reg_dst,
  output logic [31:0] ou_result,
  output logic [31:0] ou_branch_add,
  output logic        ou_zero,
  output logic [4:0]  ou_wreg,
  output logic        ou_valid,
  output logic        ou_stall
);

  ex_state_e   state, state_next;
  alu_op_e     op;
  logic [4:0]  cnt;
  logic [31:0] hi, lo, hi_n, lo_n;
  logic [31:0] op_b, alu_res, md_hi, md_lo;
  logic [31:0] res_n, br_n;
  logic [4:0]  wreg_n;
  logic        valid_n;
  logic        is_mul_op, is_div_op, start, stepping, last_step;

  assign op        = alu_op_e'(in_alu_op);
  assign op_b      = in_alu_src ? in_extend : in_dato2;
  assign is_mul_op = (op == ALU_MULTU);
`ifdef EX_DIV_EN
  assign is_div_op = (op == ALU_DIVU);
  assign stepping  = (state == ST_MUL) || (state == ST_DIV);
`else
  assign is_div_op = 1'b0;
  assign stepping  = (state == ST_MUL);
`endif
  assign start     = (state == ST_IDLE) && in_valid && (is_mul_op || is_div_op);
  assign last_step = stepping && (cnt == MD_LAST);
  assign ou_stall  = stepping || start;

  ex_muldiv u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef EX_DIV_EN
    .mode_div (is_div_op),
`endif
    .step     (stepping),
    .op_a     (in_dato1),
    .op_b     (op_b),
    .nxt_hi   (md_hi),
    .nxt_lo   (md_lo)
  );

  // Single-cycle ALU; reserved and multicycle codes produce zero.
  always_comb begin
    alu_res = '0;
    case (op)
      ALU_AND:  alu_res = in_dato1 & op_b;
      ALU_OR:   alu_res = in_dato1 | op_b;
      ALU_ADD:  alu_res = in_dato1 + op_b;
      ALU_SUB:  alu_res = in_dato1 - op_b;
      ALU_SLT:  alu_res = {31'd0, $signed(in_dato1) < $signed(op_b)};
      ALU_NOR:  alu_res = ~(in_dato1 | op_b);
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (in_valid && is_mul_op) state_next = ST_MUL;
`ifdef EX_DIV_EN
        else if (in_valid && is_div_op) state_next = ST_DIV;
`endif
      end
      ST_MUL:  if (cnt == MD_LAST) state_next = ST_DONE;
`ifdef EX_DIV_EN
      ST_DIV:  if (cnt == MD_LAST) state_next = ST_DONE;
`endif
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and HI/LO. The DONE-cycle view
  // (valid, result=LO) is loaded on the final step edge, so while the FSM
  // sits in DONE the outputs already show the new LO; DONE itself loads a
  // bubble and ignores the stale multicycle instruction still in ID/EX.
  always_comb begin
    res_n   = '0;
    br_n    = '0;
    wreg_n  = '0;
    valid_n = 1'b0;
    hi_n    = hi;
    lo_n    = lo;
    if (state == ST_IDLE) begin
      if (in_valid && !start) begin
        res_n   = alu_res;
        br_n    = branch_target(in_add, in_extend);
        wreg_n  = in_reg_dst ? in_b15_11 : in_b20_16;
        valid_n = 1'b1;
      end
    end else if (last_step) begin
      hi_n    = md_hi;
      lo_n    = md_lo;
      res_n   = md_lo;
      valid_n = 1'b1;
    end
  end

  // State, counter, HI/LO and EX/MEM output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      hi            <= '0;
      lo            <= '0;
      ou_result     <= '0;
      ou_branch_add <= '0;
      ou_zero       <= 1'b0;
      ou_wreg       <= '0;
      ou_valid      <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= stepping ? cnt + 5'd1 : '0;
      hi            <= hi_n;
      lo            <= lo_n;
      ou_result     <= res_n;
      ou_branch_add <= br_n;
      ou_zero       <= (res_n == '0);
      ou_wreg       <= wreg_n;
      ou_valid      <= valid_n;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized
// instruction stream compared against a transaction-level reference model.
// Honours EX_DIV_EN the same way the design does.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_add, in_dato1, in_dato2, in_extend;
  logic [4:0]  in_b20_16, in_b15_11;
  logic [3:0]  in_alu_op;
  logic        in_alu_src, in_reg_dst;
  logic [31:0] ou_result, ou_branch_add;
  logic        ou_zero, ou_valid, ou_stall;
  logic [4:0]  ou_wreg;

`ifdef EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_add(in_add),
    .in_dato1(in_dato1), .in_dato2(in_dato2), .in_extend(in_extend),
    .in_b20_16(in_b20_16), .in_b15_11(in_b15_11), .in_alu_op(in_alu_op),
    .in_alu_src(in_alu_src), .in_reg_dst(in_reg_dst), .ou_result(ou_result),
    .ou_branch_add(ou_branch_add), .ou_zero(ou_zero), .ou_wreg(ou_wreg),
    .ou_valid(ou_valid), .ou_stall(ou_stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: HI/LO, remaining busy cycles, pending 64-bit result.
  logic [31:0] m_hi, m_lo;
  int          m_busy;
  bit          m_done;
  logic [63:0] m_pend;
  logic [31:0] e_result, e_branch;
  logic [4:0]  e_wreg;
  logic        e_valid, e_zero;

  function automatic bit is_multi(input logic [3:0] op);
    return (op == 4'd6) || (DIV_EN && op == 4'd7);
  endfunction

  function automatic bit model_stall();
    return (m_busy > 0) || (!m_done && in_valid && is_multi(in_alu_op));
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a - b;
      4'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5: return ~(a | b);
      4'd8: return m_hi;
      4'd9: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_out(input logic v, input logic [31:0] r, input logic [4:0] w,
                         input logic [31:0] br);
    e_valid = v; e_result = r; e_wreg = w; e_branch = br; e_zero = (r == 0);
  endtask

  task automatic model_step();
    logic [31:0] b;
    b = in_alu_src ? in_extend : in_dato2;
    if (rst) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0;
      set_out(0, 0, 0, 0); e_zero = 0;
    end else if (m_done) begin
      m_done = 0; set_out(0, 0, 0, 0);
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_hi = m_pend[63:32]; m_lo = m_pend[31:0]; m_done = 1;
        set_out(1, m_lo, 0, 0);
      end else set_out(0, 0, 0, 0);
    end else if (in_valid && is_multi(in_alu_op)) begin
      if (in_alu_op == 4'd6) m_pend = {32'd0, in_dato1} * {32'd0, b};
      else if (b == 0)       m_pend = {in_dato1, 32'hFFFF_FFFF};
      else                   m_pend = {in_dato1 % b, in_dato1 / b};
      m_busy = 32;
      set_out(0, 0, 0, 0);
    end else if (in_valid) begin
      set_out(1, ref_alu(in_alu_op, in_dato1, b), in_reg_dst ? in_b15_11 : in_b20_16,
              in_add + in_extend * 4);
    end else set_out(0, 0, 0, 0);
  endtask

  // One clock: inputs already driven after the previous negedge.
  task automatic do_cycle(output bit exp_s, output bit act_s);
    #1;
    exp_s = model_stall();
    act_s = ou_stall;
    check("stall", ou_stall, exp_s);
    @(posedge clk);
    model_step();
    #1;
    check("valid", ou_valid, e_valid);
    check("result", ou_result, e_result);
    check("zero", ou_zero, e_zero);
    check("wreg", ou_wreg, e_wreg);
    check("branch", ou_branch_add, e_branch);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ext, input logic [31:0] pc4,
                       input bit src, input bit dst, input logic [4:0] rt, input logic [4:0] rd);
    in_valid = v; in_alu_op = op; in_dato1 = a; in_dato2 = b; in_extend = ext;
    in_add = pc4; in_alu_src = src; in_reg_dst = dst; in_b20_16 = rt; in_b15_11 = rd;
  endtask

  // Holds the instruction while the model says the stage is stalled.
  task automatic run_op(input bit v, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int dut_stalls);
    bit es, as;
    drive(v, op, a, b, 32'h0000_0010, 32'h0000_0400, 1'b0, 1'b1, 5'd3, 5'd9);
    dut_stalls = 0;
    do begin
      do_cycle(es, as);
      if (as) dut_stalls++;
    end while (es);
  endtask

  int ns;
  bit es, as;
  logic [3:0] rop;
  logic [31:0] ra, rb;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    m_hi = 'x; m_lo = 'x; m_busy = 0; m_done = 0;
    do_cycle(es, as);
    check("rst_result", ou_result, 0);
    check("rst_valid", ou_valid, 0);
    check("rst_zero", ou_zero, 0);
    rst = 1'b0;

    // ADD 5+7 -> rd 9
    drive(1, 4'd2, 5, 7, 0, 0, 0, 1, 5'd4, 5'd9);
    do_cycle(es, as);
    check("add_res", ou_result, 12);
    check("add_wreg", ou_wreg, 9);
    check("add_valid", ou_valid, 1);
    check("add_zero", ou_zero, 0);

    // SUB equal operands, negative immediate branch
    drive(1, 4'd3, 32'h1234, 32'h1234, 32'hFFFF_FFFF, 32'h100, 0, 0, 5'd2, 5'd0);
    do_cycle(es, as);
    check("sub_zero", ou_zero, 1);
    check("sub_branch", ou_branch_add, 32'h0000_00FC);

    // MULTU 0xFFFFFFFF * 2
    run_op(1, 4'd6, 32'hFFFF_FFFF, 2, ns);
    check("mul_stalls", ns, 33);
    run_op(1, 4'd8, 0, 0, ns);
    check("mfhi", ou_result, 1);
    run_op(1, 4'd9, 0, 0, ns);
    check("mflo", ou_result, 32'hFFFF_FFFE);

    // DIVU 100/7 and 5/0 (reserved op without the divider)
    run_op(1, 4'd7, 100, 7, ns);
    check("div_stalls", ns, DIV_EN ? 33 : 0);
    run_op(1, 4'd9, 0, 0, ns);
    check("div_lo", ou_result, DIV_EN ? 14 : 32'hFFFF_FFFE);
    run_op(1, 4'd8, 0, 0, ns);
    check("div_hi", ou_result, DIV_EN ? 2 : 1);
    run_op(1, 4'd7, 5, 0, ns);
    run_op(1, 4'd9, 0, 0, ns);
    check("div0_lo", ou_result, DIV_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFFE);
    run_op(1, 4'd8, 0, 0, ns);
    check("div0_hi", ou_result, DIV_EN ? 5 : 1);

    // Bubble between two ADDs: valid 1,0,1
    drive(1, 4'd2, 1, 2, 0, 0, 0, 1, 0, 5'd1);
    do_cycle(es, as);
    check("bub_v1", ou_valid, 1);
    in_valid = 0;
    do_cycle(es, as);
    check("bub_v0", ou_valid, 0);
    in_valid = 1;
    do_cycle(es, as);
    check("bub_v2", ou_valid, 1);
    run_op(1, 4'd8, 0, 0, ns);
    check("bub_hi", ou_result, DIV_EN ? 5 : 1);

    // Reset during MUL iteration 10
    drive(1, 4'd6, 32'd123, 32'd456, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) do_cycle(es, as);
    rst = 1'b1;
    do_cycle(es, as);
    rst = 1'b0;
    check("ab_valid", ou_valid, 0);
    check("ab_result", ou_result, 0);
    check("ab_wreg", ou_wreg, 0);
    in_valid = 0;
    #1 check("ab_stall_lo", ou_stall, 0);
    in_valid = 1;
    #1 check("ab_stall_hi", ou_stall, 1);
    run_op(1, 4'd8, 0, 0, ns);
    check("ab_hi", ou_result, 0);
    run_op(1, 4'd9, 0, 0, ns);
    check("ab_lo", ou_result, 0);

    // Randomized instruction stream
    for (int k = 0; k < 150; k++) begin
      rop = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 2) rop = 4'($urandom_range(6, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      drive($urandom_range(0, 4) != 0, rop, ra, rb, $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      do begin
        do_cycle(es, as);
      end while (es);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
